// File: rtl/mips32_boot_pkg.sv
// Shared definitions for the MIPS32 boot loader: frame marker, field offsets
// and the loader FSM encoding.
package mips32_boot_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Byte offsets of the header fields within a frame; data starts at OFF_DATA.
   localparam int OFF_SYNC    = 0;
   localparam int OFF_ADDR_HI = 1;
   localparam int OFF_ADDR_LO = 2;
   localparam int OFF_CNT_HI  = 3;
   localparam int OFF_CNT_LO  = 4;
   localparam int OFF_DATA    = 5;

   // Header states are numbered by the offset of the byte they expect next.
   typedef enum logic [3:0] {
      S_IDLE    = 4'(OFF_SYNC),
      S_ADDR_HI = 4'(OFF_ADDR_HI),
      S_ADDR_LO = 4'(OFF_ADDR_LO),
      S_CNT_HI  = 4'(OFF_CNT_HI),
      S_CNT_LO  = 4'(OFF_CNT_LO),
      S_DATA    = 4'(OFF_DATA),
      S_CKSUM   = 4'd6,
      S_START   = 4'd7,
      S_ERR     = 4'd8
   } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs data bytes MSB-first into 32-bit words and keeps the running XOR
// checksum of every data byte of the current frame.
module word_assembler (
   input  logic        clk1,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  data_byte,
   output logic        word_valid,
   output logic [31:0] word,
   output logic [7:0]  xor_acc
);

   logic [1:0]  byte_cnt;
   logic [23:0] shreg;

   // The word completes combinationally with its fourth byte so the caller
   // can register the memory write on the same edge that accepts that byte.
   assign word_valid = shift && (byte_cnt == 2'd3);
   assign word       = {shreg, data_byte};

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         byte_cnt <= 2'd0;
         shreg    <= 24'd0;
         xor_acc  <= 8'd0;
      end else if (clear) begin
         byte_cnt <= 2'd0;
         shreg    <= 24'd0;
         xor_acc  <= 8'd0;
      end else if (shift) begin
         byte_cnt <= byte_cnt + 2'd1;
         shreg    <= {shreg[15:0], data_byte};
         xor_acc  <= xor_acc ^ data_byte;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot-stage loader: parses framed bytes, writes words into core memory and
// releases the halted core with a start pulse once the checksum verifies.
module program_loader
   import mips32_boot_pkg::*;
#(
   parameter int         ADDR_W    = 10,
   parameter int         MEM_DEPTH = 1024,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   output logic [ADDR_W-1:0] start_pc,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // Handshake: a byte transfers on a rising clk1 edge when in_valid && in_ready.
   // in_ready drops only in the single-cycle START and ERR states.

   state_t state, state_nxt;

   logic [15:0]       addr_reg;
   logic [7:0]        cnt_hi;
   logic [15:0]       words_left;
   logic [ADDR_W-1:0] word_idx;

   logic        accept;
   logic        is_sync;
   logic        data_shift;
   logic        word_valid;
   logic [31:0] word;
   logic [7:0]  xor_acc;
   logic [15:0] cnt_now;
   logic [16:0] end_addr;
   logic        range_bad;
   logic        cksum_ok;

   assign in_ready   = (state != S_START) && (state != S_ERR);
   assign accept     = in_valid && in_ready;
   assign is_sync    = (state == S_IDLE) && accept && (in_data == SYNC_BYTE);
   assign data_shift = (state == S_DATA) && accept;
   assign cnt_now    = {cnt_hi, in_data};
   // Base plus count is formed one bit wider so it cannot wrap past the top.
   assign end_addr   = {1'b0, addr_reg} + {1'b0, cnt_now};
   assign range_bad  = ((addr_reg >> ADDR_W) != 16'd0) || (end_addr > 17'(MEM_DEPTH));
   assign cksum_ok   = (in_data == xor_acc);

   word_assembler u_asm (
      .clk1       (clk1),
      .rst        (rst),
      .clear      (is_sync),
      .shift      (data_shift),
      .data_byte  (in_data),
      .word_valid (word_valid),
      .word       (word),
      .xor_acc    (xor_acc)
   );

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (is_sync) state_nxt = S_ADDR_HI;
         S_ADDR_HI: if (accept)  state_nxt = S_ADDR_LO;
         S_ADDR_LO: if (accept)  state_nxt = S_CNT_HI;
         S_CNT_HI:  if (accept)  state_nxt = S_CNT_LO;
         S_CNT_LO: begin
            if (accept) begin
               if (range_bad)              state_nxt = S_ERR;
               else if (cnt_now != 16'd0)  state_nxt = S_DATA;
               else                        state_nxt = S_CKSUM;
            end
         end
         S_DATA:    if (word_valid && (words_left == 16'd1)) state_nxt = S_CKSUM;
         S_CKSUM:   if (accept) state_nxt = cksum_ok ? S_START : S_ERR;
         S_START:   state_nxt = S_IDLE;
         S_ERR:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         addr_reg   <= 16'd0;
         cnt_hi     <= 8'd0;
         words_left <= 16'd0;
         word_idx   <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'd0;
         cpu_hold   <= 1'b1;
         cpu_start  <= 1'b0;
         start_pc   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         cpu_start <= 1'b0;
         if (is_sync) begin
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
         end
         if (accept && (state == S_ADDR_HI)) addr_reg[15:8] <= in_data;
         if (accept && (state == S_ADDR_LO)) addr_reg[7:0]  <= in_data;
         if (accept && (state == S_CNT_HI))  cnt_hi         <= in_data;
         if (accept && (state == S_CNT_LO)) begin
            words_left <= cnt_now;
            word_idx   <= '0;
         end
         if (word_valid) begin
            mem_we     <= 1'b1;
            mem_addr   <= addr_reg[ADDR_W-1:0] + word_idx;
            mem_wdata  <= word;
            word_idx   <= word_idx + 1'b1;
            words_left <= words_left - 16'd1;
         end
         // Control outputs are registered so they are visible during START/ERR.
         if ((state != S_START) && (state_nxt == S_START)) begin
            cpu_start <= 1'b1;
            start_pc  <= addr_reg[ADDR_W-1:0];
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
         end
         if ((state != S_ERR) && (state_nxt == S_ERR)) begin
            error <= 1'b1;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: frames go in through the
// byte handshake, memory writes and start pulses are logged and checked.
module tb_program_loader;

   localparam int ADDR_W = 10;
   localparam int SW     = ADDR_W + 32;

   logic              clk1 = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              cpu_start;
   logic [ADDR_W-1:0] start_pc;
   logic              busy;
   logic              done;
   logic              error;

   always #5 clk1 = ~clk1;

   program_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(1024), .SYNC_BYTE(8'hA5)) dut (
      .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
      .cpu_start(cpu_start), .start_pc(start_pc), .busy(busy), .done(done), .error(error)
   );

   int errors = 0;
   int checks = 0;

   logic [SW-1:0] exp_q[$];
   logic [SW-1:0] got_q[$];
   logic [7:0]    frame_q[$];

   int                cyc = 0;
   int                we_cyc = 0;
   int                start_cyc = 0;
   int                start_cnt = 0;
   logic [ADDR_W-1:0] start_pc_seen = '0;
   logic              prev_start = 1'b0;
   logic [2:0]        flags = 3'b000;   // {overlap, ready_in_start, long_pulse}

   localparam logic [58:0] RESET_VEC = {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd0, 3'b000};

   function automatic logic [58:0] obs_vec();
      return {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, start_pc, busy, done, error};
   endfunction

   always @(negedge clk1) begin
      cyc++;
      if (mem_we) begin
         got_q.push_back({mem_addr, mem_wdata});
         we_cyc = cyc;
      end
      if (cpu_start) begin
         start_cnt++;
         start_cyc     = cyc;
         start_pc_seen = start_pc;
         if (mem_we)     flags[2] = 1'b1;
         if (in_ready)   flags[1] = 1'b1;
         if (prev_start) flags[0] = 1'b1;
      end
      prev_start = cpu_start;
   end

   task automatic clear_logs();
      exp_q.delete();
      got_q.delete();
      start_cnt = 0;
      flags     = 3'b000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk1);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 20) begin
         @(negedge clk1);
         guard++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
      end
      @(negedge clk1);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap);
      foreach (frame_q[i]) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk1);
         send_byte(frame_q[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      idle(3);
      checks++;
      if (obs_vec() !== RESET_VEC) begin errors++; $display("FAIL reset_values: got %h required %h", obs_vec(), RESET_VEC); end
      @(negedge clk1);
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_single_word();
      clear_logs();
      frame_q = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFC};
      exp_q.push_back({10'd7, 32'hFC00_0000});
      send_frame(0);
      idle(3);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_write_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_write_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (start_cnt != 1) begin errors++; $display("FAIL single_start_count: got %0d required 1", start_cnt); end
      checks++; if (start_pc_seen !== 10'd7) begin errors++; $display("FAIL single_start_pc: got %h required 007", start_pc_seen); end
      checks++; if (start_cyc - we_cyc != 1) begin errors++; $display("FAIL single_start_latency: got %0d required 1", start_cyc - we_cyc); end
      checks++; if ({done, cpu_hold, error, busy} !== 4'b1000) begin errors++; $display("FAIL single_status: got %b required 1000", {done, cpu_hold, error, busy}); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL single_pulse_flags: got %b required 000", flags); end
   endtask

   task automatic test_bad_checksum();
      clear_logs();
      frame_q = '{8'hA5};
      send_frame(0);
      #1;
      checks++; if ({cpu_hold, busy, done} !== 3'b110) begin errors++; $display("FAIL reload_hold: got %b required 110", {cpu_hold, busy, done}); end
      frame_q = '{8'h00, 8'h07, 8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_q.push_back({10'd7, 32'hFC00_0000});
      send_frame(0);
      idle(3);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL badck_write: got %0d writes required 1 of %h", got_q.size(), exp_q[0]); end
      checks++; if (start_cnt != 0) begin errors++; $display("FAIL badck_start_count: got %0d required 0", start_cnt); end
      checks++; if ({error, cpu_hold, done, busy} !== 4'b1100) begin errors++; $display("FAIL badck_status: got %b required 1100", {error, cpu_hold, done, busy}); end
   endtask

   task automatic test_empty();
      clear_logs();
      frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(1);
      idle(3);
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL empty_write_count: got %0d required 0", got_q.size()); end
      checks++; if (start_cnt != 1) begin errors++; $display("FAIL empty_start_count: got %0d required 1", start_cnt); end
      checks++; if (start_pc !== 10'd0) begin errors++; $display("FAIL empty_start_pc: got %h required 000", start_pc); end
      checks++; if ({done, cpu_hold, error} !== 3'b100) begin errors++; $display("FAIL empty_status: got %b required 100", {done, cpu_hold, error}); end
   endtask

   task automatic test_range();
      clear_logs();
      frame_q = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02};
      send_frame(0);
      idle(3);
      checks++; if ({error, busy, cpu_hold, done} !== 4'b1010) begin errors++; $display("FAIL range_end_status: got %b required 1010", {error, busy, cpu_hold, done}); end
      frame_q = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h01};
      send_frame(0);
      idle(3);
      checks++; if ({error, busy, cpu_hold} !== 3'b101) begin errors++; $display("FAIL range_addr_status: got %b required 101", {error, busy, cpu_hold}); end
      checks++; if (got_q.size() != 0 || start_cnt != 0) begin errors++; $display("FAIL range_activity: got %0d writes %0d starts required 0 0", got_q.size(), start_cnt); end
      // Last word of memory is a legal one-word frame.
      frame_q = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      exp_q.push_back({10'h3FF, 32'h1122_3344});
      send_frame(0);
      idle(3);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL range_top_write: got %0d writes required 1 of %h", got_q.size(), exp_q[0]); end
      checks++; if (start_pc_seen !== 10'h3FF || start_cnt != 1) begin errors++; $display("FAIL range_top_start: got pc %h count %0d required 3ff 1", start_pc_seen, start_cnt); end
   endtask

   task automatic test_sync_in_data();
      clear_logs();
      frame_q = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
      exp_q.push_back({10'h0A5, 32'hA5A5_A5A5});
      send_frame(0);
      idle(3);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL sync_data_write: got %0d writes required 1 of %h", got_q.size(), exp_q[0]); end
      checks++; if (start_pc_seen !== 10'h0A5 || done !== 1'b1) begin errors++; $display("FAIL sync_data_start: got pc %h done %b required 0a5 1", start_pc_seen, done); end
   endtask

   task automatic test_full_program();
      logic [31:0] prog [8];
      prog = '{32'h2801_0078, 32'h0C63_1800, 32'h2022_0000, 32'h0C63_1800,
               32'h2842_002D, 32'h0C63_1800, 32'h2422_0001, 32'hFC00_0000};
      clear_logs();
      frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h08};
      for (int i = 0; i < 8; i++) begin
         for (int b = 3; b >= 0; b--) frame_q.push_back(prog[i][b*8 +: 8]);
         exp_q.push_back({10'(i), prog[i]});
      end
      frame_q.push_back(8'h98);
      send_frame(3);
      idle(3);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL prog_write_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL prog_write_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (start_cnt != 1 || start_pc_seen !== 10'd0) begin errors++; $display("FAIL prog_start: got count %0d pc %h required 1 000", start_cnt, start_pc_seen); end
      checks++; if ({done, cpu_hold, error, flags} !== 6'b100000) begin errors++; $display("FAIL prog_status: got %b required 100000", {done, cpu_hold, error, flags}); end
   endtask

   task automatic test_reset_mid_frame();
      clear_logs();
      frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h04,
                  8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33};
      exp_q.push_back({10'h010, 32'h1111_1111});
      exp_q.push_back({10'h011, 32'h2222_2222});
      send_frame(0);
      rst = 1'b1;
      #1;
      checks++;
      if (obs_vec() !== RESET_VEC) begin errors++; $display("FAIL midreset_values: got %h required %h", obs_vec(), RESET_VEC); end
      checks++;
      if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin errors++; $display("FAIL midreset_prior_writes: got %0d writes required 2", got_q.size()); end
      @(negedge clk1);
      rst = 1'b0;
      clear_logs();
      frame_q = '{8'h00, 8'h12, 8'hFF, 8'h03, 8'h5A};
      send_frame(0);
      idle(2);
      checks++; if (busy !== 1'b0 || got_q.size() != 0) begin errors++; $display("FAIL garbage_ignored: got busy %b writes %0d required 0 0", busy, got_q.size()); end
      frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      exp_q.push_back({10'h020, 32'hDEAD_BEEF});
      send_frame(2);
      idle(3);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL clean_write: got %0d writes required 1 of %h", got_q.size(), exp_q[0]); end
      checks++; if (start_cnt != 1 || start_pc_seen !== 10'h020 || done !== 1'b1) begin errors++; $display("FAIL clean_start: got count %0d pc %h done %b required 1 020 1", start_cnt, start_pc_seen, done); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_bad_checksum();
      test_empty();
      test_range();
      test_sync_in_data();
      test_full_program();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
